// File: rtl/wb_skid_stage.sv
// Writeback skid stage: head + skid register pair with registered in_ready.
// Ports: in_* upstream entry, out_* head entry, flush, occ; fwd_* with WB_FWD_EN.
module wb_skid_stage #(
  parameter int WIDTH = 16,
  parameter int RAW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_wen,
  input  logic [RAW-1:0]   in_wr_reg,
  input  logic [WIDTH-1:0] in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_reg_wen,
  output logic [RAW-1:0]   out_wr_reg,
  output logic [WIDTH-1:0] out_result,
  input  logic             flush,
  output logic [1:0]       occ
`ifdef WB_FWD_EN
  ,
  input  logic [RAW-1:0]   fwd_rs1,
  input  logic [RAW-1:0]   fwd_rs2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [WIDTH-1:0] fwd_data1,
  output logic [WIDTH-1:0] fwd_data2
`endif
);

  logic             h_v;
  logic             h_wen;
  logic [RAW-1:0]   h_reg;
  logic [WIDTH-1:0] h_res;
  logic             s_v;
  logic             s_wen;
  logic [RAW-1:0]   s_reg;
  logic [WIDTH-1:0] s_res;

  logic accept;
  logic pop;
  logic in_wen;

  assign in_ready = ~s_v;
  assign accept   = in_valid & in_ready;
  assign pop      = h_v & out_ready;
  // writes to x0 travel as bubbles that never write
  assign in_wen   = in_reg_wen & (in_wr_reg != '0);

  assign out_valid   = h_v;
  assign out_reg_wen = h_wen;
  assign out_wr_reg  = h_reg;
  assign out_result  = h_res;
  assign occ         = {1'b0, h_v} + {1'b0, s_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_v   <= 1'b0;
      h_wen <= 1'b0;
      h_reg <= '0;
      h_res <= '0;
      s_v   <= 1'b0;
      s_wen <= 1'b0;
      s_reg <= '0;
      s_res <= '0;
    end else if (flush) begin
      h_v <= 1'b0;
      s_v <= 1'b0;
    end else if (!h_v || pop) begin
      if (s_v) begin
        h_v   <= 1'b1;
        h_wen <= s_wen;
        h_reg <= s_reg;
        h_res <= s_res;
        s_v   <= 1'b0;
      end else if (accept) begin
        h_v   <= 1'b1;
        h_wen <= in_wen;
        h_reg <= in_wr_reg;
        h_res <= in_result;
      end else begin
        h_v <= 1'b0;
      end
    end else if (accept) begin
      s_v   <= 1'b1;
      s_wen <= in_wen;
      s_reg <= in_wr_reg;
      s_res <= in_result;
    end
  end

`ifdef WB_FWD_EN
  // skid holds the younger entry, so it takes priority
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    if (fwd_rs1 != '0) begin
      if (s_v && s_wen && s_reg == fwd_rs1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = s_res;
      end else if (h_v && h_wen && h_reg == fwd_rs1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = h_res;
      end
    end
  end

  always_comb begin
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    if (fwd_rs2 != '0) begin
      if (s_v && s_wen && s_reg == fwd_rs2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = s_res;
      end else if (h_v && h_wen && h_reg == fwd_rs2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = h_res;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_skid_stage.sv
// Testbench for wb_skid_stage: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_wb_skid_stage;

  typedef struct packed {
    logic        wen;
    logic [4:0]  r;
    logic [15:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_wen;
  logic [4:0]  in_wr_reg;
  logic [15:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic        out_reg_wen;
  logic [4:0]  out_wr_reg;
  logic [15:0] out_result;
  logic        flush;
  logic [1:0]  occ;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rs1;
  logic [4:0]  fwd_rs2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];
  ent_t last;

  wb_skid_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_reg_wen (in_reg_wen),
    .in_wr_reg  (in_wr_reg),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_reg_wen(out_reg_wen),
    .out_wr_reg (out_wr_reg),
    .out_result (out_result),
    .flush      (flush),
    .occ        (occ)
`ifdef WB_FWD_EN
    ,
    .fwd_rs1    (fwd_rs1),
    .fwd_rs2    (fwd_rs2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef WB_FWD_EN
  task automatic fwd_model(input logic [4:0] rs,
                           output logic hit, output logic [15:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 0)
      for (int i = 0; i < q.size(); i++)
        if (q[i].wen && q[i].r == rs) begin
          hit = 1'b1;
          d   = q[i].d;
        end
  endtask
`endif

  task automatic check_outs();
`ifdef WB_FWD_EN
    logic        h;
    logic [15:0] d;
`endif
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("occ", 32'(occ), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_reg_wen", 32'(out_reg_wen), 32'(last.wen));
    chk("out_wr_reg", 32'(out_wr_reg), 32'(last.r));
    chk("out_result", 32'(out_result), 32'(last.d));
`ifdef WB_FWD_EN
    fwd_model(fwd_rs1, h, d);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
    chk("fwd_data1", 32'(fwd_data1), 32'(d));
    fwd_model(fwd_rs2, h, d);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
    chk("fwd_data2", 32'(fwd_data2), 32'(d));
`endif
  endtask

  task automatic cycle();
    bit   acc;
    bit   pp;
    ent_t e;
    acc = in_valid && q.size() < 2;
    pp  = q.size() > 0 && out_ready;
    e.wen = in_reg_wen && (in_wr_reg != 0);
    e.r   = in_wr_reg;
    e.d   = in_result;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last = q[0];
    @(negedge clk);
    check_outs();
  endtask

  task automatic drive(bit v, bit w, logic [4:0] r, logic [15:0] d);
    in_valid   = v;
    in_reg_wen = w;
    in_wr_reg  = r;
    in_result  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    last = '0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_wen", 32'(out_reg_wen), 0);
    chk("rst_out_reg", 32'(out_wr_reg), 0);
    chk("rst_out_res", 32'(out_result), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0);
`ifdef WB_FWD_EN
    fwd_rs1 = '0;
    fwd_rs2 = '0;
`endif
    @(negedge clk);
    do_reset();

    // single accept, one-cycle latency, then pop
    out_ready = 1'b1;
    drive(1, 1, 3, 16'h1234);
    cycle();
    drive(0, 0, 0, 0);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_reg", 32'(out_wr_reg), 3);
    chk("lat_res", 32'(out_result), 32'h1234);
    cycle();
    chk("lat_occ", 32'(occ), 0);

    // backpressure fills head and skid
    out_ready = 1'b0;
    drive(1, 1, 1, 16'h0001);
    cycle();
    drive(1, 1, 2, 16'h0002);
    cycle();
    drive(0, 0, 0, 0);
    chk("bp_occ", 32'(occ), 2);
    chk("bp_ready", 32'(in_ready), 0);
    chk("bp_head", 32'(out_result), 32'h0001);
    cycle();
    chk("bp_hold", 32'(out_result), 32'h0001);
    out_ready = 1'b1;
    cycle();
    chk("bp_b", 32'(out_result), 32'h0002);
    chk("bp_ready1", 32'(in_ready), 1);
    cycle();
    chk("bp_empty", 32'(occ), 0);

    // x0 destination suppresses the write
    drive(1, 1, 0, 16'hFFFF);
    out_ready = 1'b0;
    cycle();
    drive(0, 0, 0, 0);
    chk("x0_valid", 32'(out_valid), 1);
    chk("x0_wen", 32'(out_reg_wen), 0);
    chk("x0_res", 32'(out_result), 32'hFFFF);
    out_ready = 1'b1;
    cycle();

`ifdef WB_FWD_EN
    // younger skid entry wins the forward
    out_ready = 1'b0;
    drive(1, 1, 5, 16'h00AA);
    cycle();
    drive(1, 1, 5, 16'h00BB);
    cycle();
    drive(0, 0, 0, 0);
    fwd_rs1 = 5;
    fwd_rs2 = 0;
    #1;
    chk("fwd_hit1_dir", 32'(fwd_hit1), 1);
    chk("fwd_data1_dir", 32'(fwd_data1), 32'h00BB);
    chk("fwd_hit2_dir", 32'(fwd_hit2), 0);
    chk("fwd_data2_dir", 32'(fwd_data2), 0);
    out_ready = 1'b1;
    cycle();
    cycle();
`endif

    // flush at full occupancy kills the same-cycle input
    out_ready = 1'b0;
    drive(1, 1, 7, 16'h0A0A);
    cycle();
    drive(1, 1, 8, 16'h0B0B);
    cycle();
    drive(1, 1, 9, 16'hDEAD);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(0, 0, 0, 0);
    chk("fl_occ", 32'(occ), 0);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_gone", 32'(out_valid), 0);
    end

    // random traffic, with an asynchronous reset mid-stream
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 4 != 0, 1'($urandom), 5'($urandom),
            16'($urandom));
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 50) == 0;
`ifdef WB_FWD_EN
      fwd_rs1 = 5'($urandom % 8);
      fwd_rs2 = 5'($urandom % 8);
`endif
      if (i == 200) begin
        #2;
        do_reset();
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
